// File: rtl/data_bus_xbar_pkg.sv
// Shared definitions for the data bus crossbar: default address map constants
// and index-width helper.
package data_bus_xbar_pkg;

   localparam logic [31:0] DATA_MEM_BASE = 32'h0000_1000;
   localparam logic [31:0] DATA_MEM_MASK = 32'hFFFF_F000;
   localparam logic [31:0] GPIO_A_BASE   = 32'h0000_0400;
   localparam logic [31:0] GPIO_A_MASK   = 32'hFFFF_FC00;

   typedef enum logic {
      ACC_READ  = 1'b0,
      ACC_WRITE = 1'b1
   } acc_kind_e;

   // A single target still needs a one-bit index so vectors never collapse to zero width.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_bus_xbar_if.sv
// Core-side read/write port of the data bus crossbar.
interface data_bus_xbar_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              r_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_err;
   logic              w_en;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              w_err;

   modport master (
      output r_en, r_addr, w_en, w_addr, w_data,
      input  r_data, r_valid, r_err, w_err
   );

   modport slave (
      input  r_en, r_addr, w_en, w_addr, w_data,
      output r_data, r_valid, r_err, w_err
   );
endinterface

// File: rtl/data_bus_xbar_decoder.sv
// Address decoder: base/mask match per target, lowest index wins, and the
// target-local address with the matched mask bits stripped.
module bus_addr_decoder
   import data_bus_xbar_pkg::*;
#(
   parameter int                          N_SLAVES = 4,
   parameter int                          ADDR_W   = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_BASE = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_MASK = '0,
   localparam int                         IDX_W    = idx_w(N_SLAVES)
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [IDX_W-1:0]  idx,
   output logic [ADDR_W-1:0] local_addr
);

   logic [N_SLAVES-1:0] match;

   for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
      assign match[gi] = (addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
   end

   // Scan downwards so the lowest matching slot is the last one written.
   always_comb begin
      hit        = 1'b0;
      idx        = '0;
      local_addr = addr;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit        = 1'b1;
            idx        = IDX_W'(i);
            local_addr = addr & ~SLV_MASK[i*ADDR_W +: ADDR_W];
         end
      end
   end

endmodule

// File: rtl/data_bus_xbar.sv
// Data bus crossbar: one read and one write port fanned out to N_SLAVES targets,
// with a latency-matched read return pipeline and sticky unmapped-access capture.
module data_bus_xbar
   import data_bus_xbar_pkg::*;
#(
   parameter int                          N_SLAVES = 4,
   parameter int                          ADDR_W   = 32,
   parameter int                          DATA_W   = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_BASE = {N_SLAVES{32'h0}},
   parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_MASK = {N_SLAVES{32'hFFFFF000}},
   parameter int                          RD_LAT   = 1,
   parameter logic [DATA_W-1:0]           ERR_DATA = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   data_bus_xbar_if.slave               bus,
   output logic [N_SLAVES-1:0]          s_r_en,
   output logic [ADDR_W-1:0]            s_r_addr,
   input  logic [N_SLAVES*DATA_W-1:0]   s_r_data,
   output logic [N_SLAVES-1:0]          s_w_en,
   output logic [ADDR_W-1:0]            s_w_addr,
   output logic [DATA_W-1:0]            s_w_data,
   output logic                         err_flag,
   output logic [ADDR_W-1:0]            err_addr,
   output logic                         err_is_write,
   input  logic                         err_clr
);

   localparam int IDX_W = idx_w(N_SLAVES);

   logic             r_hit, w_hit;
   logic [IDX_W-1:0] r_idx, w_idx;
   logic             r_miss, w_miss;

   bus_addr_decoder #(
      .N_SLAVES (N_SLAVES),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_rd_dec (
      .addr       (bus.r_addr),
      .hit        (r_hit),
      .idx        (r_idx),
      .local_addr (s_r_addr)
   );

   bus_addr_decoder #(
      .N_SLAVES (N_SLAVES),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_wr_dec (
      .addr       (bus.w_addr),
      .hit        (w_hit),
      .idx        (w_idx),
      .local_addr (s_w_addr)
   );

   assign r_miss   = bus.r_en & ~r_hit;
   assign w_miss   = bus.w_en & ~w_hit;
   assign s_w_data = bus.w_data;

   for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_en
      assign s_r_en[gi] = bus.r_en & r_hit & (r_idx == IDX_W'(gi));
      assign s_w_en[gi] = bus.w_en & w_hit & (w_idx == IDX_W'(gi));
   end

   // Return-select pipeline; the tail stage lines up with the slaves' read data.
   logic             pipe_valid_reg [RD_LAT];
   logic             pipe_miss_reg  [RD_LAT];
   logic [IDX_W-1:0] pipe_idx_reg   [RD_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_valid_reg[i] <= 1'b0;
            pipe_miss_reg[i]  <= 1'b0;
            pipe_idx_reg[i]   <= '0;
         end
      end else begin
         pipe_valid_reg[0] <= bus.r_en;
         pipe_miss_reg[0]  <= ~r_hit;
         pipe_idx_reg[0]   <= r_idx;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid_reg[i] <= pipe_valid_reg[i-1];
            pipe_miss_reg[i]  <= pipe_miss_reg[i-1];
            pipe_idx_reg[i]   <= pipe_idx_reg[i-1];
         end
      end
   end

   logic              ret_valid, ret_miss;
   logic [IDX_W-1:0]  ret_idx;
   logic [DATA_W-1:0] ret_slave_data, ret_data, r_data_hold_reg;

   assign ret_valid = pipe_valid_reg[RD_LAT-1];
   assign ret_miss  = pipe_miss_reg[RD_LAT-1];
   assign ret_idx   = pipe_idx_reg[RD_LAT-1];

   always_comb begin
      ret_slave_data = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (ret_idx == IDX_W'(i)) begin
            ret_slave_data = s_r_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ret_data = ret_miss ? ERR_DATA : ret_slave_data;

   // Keeps r_data stable between returns without delaying the return itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_hold_reg <= '0;
      end else if (ret_valid) begin
         r_data_hold_reg <= ret_data;
      end
   end

   assign bus.r_valid = ret_valid;
   assign bus.r_err   = ret_valid & ret_miss;
   assign bus.r_data  = ret_valid ? ret_data : r_data_hold_reg;

   logic w_err_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_err_reg <= 1'b0;
      end else begin
         w_err_reg <= w_miss;
      end
   end

   assign bus.w_err = w_err_reg;

   logic              err_flag_reg;
   logic [ADDR_W-1:0] err_addr_reg;
   acc_kind_e         err_kind_reg;

   // A new miss beats a same-cycle clear; a read miss beats a write miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flag_reg <= 1'b0;
         err_addr_reg <= '0;
         err_kind_reg <= ACC_READ;
      end else if ((r_miss | w_miss) && (!err_flag_reg || err_clr)) begin
         err_flag_reg <= 1'b1;
         err_addr_reg <= r_miss ? bus.r_addr : bus.w_addr;
         err_kind_reg <= r_miss ? ACC_READ : ACC_WRITE;
      end else if (err_clr) begin
         err_flag_reg <= 1'b0;
      end
   end

   assign err_flag     = err_flag_reg;
   assign err_addr     = err_addr_reg;
   assign err_is_write = (err_kind_reg == ACC_WRITE);

endmodule

// File: tb/tb_data_bus_xbar.sv
// Bench for data_bus_xbar: a directed vector table on a two-target, single-latency
// instance and model-checked random traffic on a four-target, two-latency instance.
module tb_data_bus_xbar;
   import data_bus_xbar_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slv_word(input int i, input logic [31:0] la);
      logic [3:0] id;
      id = 4'(i);
      return {8'hA0, id, 4'h0, la[15:0]};
   endfunction

   // ---------------- instance A: two targets, RD_LAT = 1 ----------------
   localparam logic [63:0] A_BASE = {GPIO_A_BASE, DATA_MEM_BASE};
   localparam logic [63:0] A_MASK = {GPIO_A_MASK, DATA_MEM_MASK};
   localparam logic [31:0] A_ERR  = 32'hDEAD_BEEF;

   data_bus_xbar_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
   logic [1:0]  a_s_r_en, a_s_w_en;
   logic [31:0] a_s_r_addr, a_s_w_addr, a_s_w_data, a_err_addr;
   logic [63:0] a_s_r_data;
   logic        a_err_flag, a_err_is_write, a_err_clr;

   data_bus_xbar #(
      .N_SLAVES(2), .ADDR_W(32), .DATA_W(32), .SLV_BASE(A_BASE), .SLV_MASK(A_MASK),
      .RD_LAT(1), .ERR_DATA(A_ERR)
   ) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a),
      .s_r_en(a_s_r_en), .s_r_addr(a_s_r_addr), .s_r_data(a_s_r_data),
      .s_w_en(a_s_w_en), .s_w_addr(a_s_w_addr), .s_w_data(a_s_w_data),
      .err_flag(a_err_flag), .err_addr(a_err_addr), .err_is_write(a_err_is_write),
      .err_clr(a_err_clr)
   );

   logic [31:0] a_addr_d;
   logic [1:0]  a_en_d;
   always @(posedge clk) begin
      a_addr_d <= a_s_r_addr;
      a_en_d   <= a_s_r_en;
   end
   always_comb begin
      a_s_r_data = '0;
      for (int i = 0; i < 2; i++)
         a_s_r_data[i*32 +: 32] = a_en_d[i] ? slv_word(i, a_addr_d) : (32'hBAD0_0000 | 32'(i));
   end

   // ---------------- instance B: four targets, RD_LAT = 2, overlapping slot 2 ----------------
   localparam logic [127:0] B_BASE = {32'h0000_8000, 32'h0000_1000, GPIO_A_BASE, DATA_MEM_BASE};
   localparam logic [127:0] B_MASK = {32'hFFFF_8000, 32'hFFFF_FF00, GPIO_A_MASK, DATA_MEM_MASK};
   localparam logic [31:0]  B_ERR  = 32'hE77E_0000;
   localparam logic [31:0]  MB_BASE [4] = '{32'h1000, 32'h400, 32'h1000, 32'h8000};
   localparam logic [31:0]  MB_MASK [4] = '{32'hFFFFF000, 32'hFFFFFC00, 32'hFFFFFF00, 32'hFFFF8000};

   data_bus_xbar_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
   logic [3:0]   b_s_r_en, b_s_w_en;
   logic [31:0]  b_s_r_addr, b_s_w_addr, b_s_w_data, b_err_addr;
   logic [127:0] b_s_r_data;
   logic         b_err_flag, b_err_is_write, b_err_clr;

   data_bus_xbar #(
      .N_SLAVES(4), .ADDR_W(32), .DATA_W(32), .SLV_BASE(B_BASE), .SLV_MASK(B_MASK),
      .RD_LAT(2), .ERR_DATA(B_ERR)
   ) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b),
      .s_r_en(b_s_r_en), .s_r_addr(b_s_r_addr), .s_r_data(b_s_r_data),
      .s_w_en(b_s_w_en), .s_w_addr(b_s_w_addr), .s_w_data(b_s_w_data),
      .err_flag(b_err_flag), .err_addr(b_err_addr), .err_is_write(b_err_is_write),
      .err_clr(b_err_clr)
   );

   logic [31:0] b_addr_d1, b_addr_d2;
   logic [3:0]  b_en_d1, b_en_d2;
   always @(posedge clk) begin
      b_addr_d1 <= b_s_r_addr;
      b_addr_d2 <= b_addr_d1;
      b_en_d1   <= b_s_r_en;
      b_en_d2   <= b_en_d1;
   end
   always_comb begin
      b_s_r_data = '0;
      for (int i = 0; i < 4; i++)
         b_s_r_data[i*32 +: 32] = b_en_d2[i] ? slv_word(i, b_addr_d2) : (32'hBAD0_0000 | 32'(i));
   end

   // ---------------- reference model for instance B ----------------
   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } ret_t;

   ret_t        q[$];
   int          b_cyc = 0;
   logic        m_flag = 1'b0, m_iw = 1'b0, m_werr = 1'b0;
   logic [31:0] m_eaddr = '0, m_last = '0;

   function automatic void b_decode(input logic [31:0] a, output logic hit, output int idx);
      hit = 1'b0;
      idx = 0;
      for (int i = 0; i < 4; i++) begin
         if ((a & MB_MASK[i]) == MB_BASE[i]) begin
            hit = 1'b1;
            idx = i;
            break;
         end
      end
   endfunction

   function automatic logic [31:0] pick_addr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0:       return 32'h1000 + {20'h0, r[11:0]};
         1:       return 32'h0400 + {22'h0, r[9:0]};
         2:       return 32'h8000 + {17'h0, r[14:0]};
         3:       return r;
         4:       return 32'h2000 + {20'h0, r[11:0]};
         default: return {22'h0, r[9:0]};
      endcase
   endfunction

   task automatic b_cycle(input logic ren, input logic [31:0] ra, input logic wen,
                          input logic [31:0] wa, input logic [31:0] wd, input logic clr);
      logic        rh, wh, exp_v;
      int          ri, wi;
      logic [3:0]  e_ren, e_wen;
      logic [31:0] r_loc;
      bus_b.r_en   = ren;
      bus_b.r_addr = ra;
      bus_b.w_en   = wen;
      bus_b.w_addr = wa;
      bus_b.w_data = wd;
      b_err_clr    = clr;
      #4;
      b_decode(ra, rh, ri);
      b_decode(wa, wh, wi);
      e_ren = (ren && rh) ? 4'(1 << ri) : 4'h0;
      e_wen = (wen && wh) ? 4'(1 << wi) : 4'h0;
      r_loc = ra & ~MB_MASK[ri];
      chk($sformatf("B%0d s_r_en", b_cyc), 32'(b_s_r_en), 32'(e_ren));
      if (e_ren != 0) chk($sformatf("B%0d s_r_addr", b_cyc), b_s_r_addr, r_loc);
      chk($sformatf("B%0d s_w_en", b_cyc), 32'(b_s_w_en), 32'(e_wen));
      if (e_wen != 0) chk($sformatf("B%0d s_w_addr", b_cyc), b_s_w_addr, wa & ~MB_MASK[wi]);
      chk($sformatf("B%0d s_w_data", b_cyc), b_s_w_data, wd);
      exp_v = (q.size() > 0) && (q[0].due == b_cyc);
      chk($sformatf("B%0d r_valid", b_cyc), 32'(bus_b.r_valid), 32'(exp_v));
      if (exp_v) begin
         chk($sformatf("B%0d r_data", b_cyc), bus_b.r_data, q[0].data);
         chk($sformatf("B%0d r_err", b_cyc), 32'(bus_b.r_err), 32'(q[0].err));
         m_last = q[0].data;
         void'(q.pop_front());
      end else begin
         chk($sformatf("B%0d r_data hold", b_cyc), bus_b.r_data, m_last);
      end
      chk($sformatf("B%0d w_err", b_cyc), 32'(bus_b.w_err), 32'(m_werr));
      chk($sformatf("B%0d err_flag", b_cyc), 32'(b_err_flag), 32'(m_flag));
      chk($sformatf("B%0d err_addr", b_cyc), b_err_addr, m_eaddr);
      chk($sformatf("B%0d err_is_write", b_cyc), 32'(b_err_is_write), 32'(m_iw));
      if (ren) q.push_back('{b_cyc + 2, rh ? slv_word(ri, r_loc) : B_ERR, !rh});
      if (((ren && !rh) || (wen && !wh)) && (!m_flag || clr)) begin
         m_flag  = 1'b1;
         m_eaddr = (ren && !rh) ? ra : wa;
         m_iw    = !(ren && !rh);
      end else if (clr) begin
         m_flag = 1'b0;
      end
      m_werr = wen && !wh;
      @(posedge clk);
      #1;
      b_cyc++;
   endtask

   // ---------------- vector table for instance A ----------------
   typedef struct {
      logic        r_en;
      logic [31:0] r_addr;
      logic        w_en;
      logic [31:0] w_addr;
      logic        clr;
      logic [1:0]  e_sren;
      logic [31:0] e_sraddr;
      logic [1:0]  e_swen;
      logic [31:0] e_swaddr;
      logic        e_rvalid;
      logic [31:0] e_rdata;
      logic        e_rerr;
      logic        e_werr;
      logic        e_flag;
      logic [31:0] e_eaddr;
      logic        e_iw;
   } vec_t;

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{0, 32'h0,    0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0,    0};
      tbl[1]  = '{1, 32'h1004, 0, 32'h0,    0, 2'b01, 32'h004, 2'b00, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0,    0};
      tbl[2]  = '{0, 32'h0,    0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   1, 32'hA0000004, 0, 0, 0, 32'h0,    0};
      tbl[3]  = '{1, 32'h3000, 0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   0, 32'hA0000004, 0, 0, 0, 32'h0,    0};
      tbl[4]  = '{0, 32'h0,    0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   1, A_ERR,        1, 0, 1, 32'h3000, 0};
      tbl[5]  = '{0, 32'h0,    1, 32'h5000, 0, 2'b00, 32'h0,   2'b00, 32'h0,   0, A_ERR,        0, 0, 1, 32'h3000, 0};
      tbl[6]  = '{0, 32'h0,    0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   0, A_ERR,        0, 1, 1, 32'h3000, 0};
      tbl[7]  = '{0, 32'h0,    0, 32'h0,    1, 2'b00, 32'h0,   2'b00, 32'h0,   0, A_ERR,        0, 0, 1, 32'h3000, 0};
      tbl[8]  = '{1, 32'h2000, 1, 32'h6000, 0, 2'b00, 32'h0,   2'b00, 32'h0,   0, A_ERR,        0, 0, 0, 32'h3000, 0};
      tbl[9]  = '{0, 32'h0,    1, 32'h0404, 0, 2'b00, 32'h0,   2'b10, 32'h004, 1, A_ERR,        1, 1, 1, 32'h2000, 0};
      tbl[10] = '{0, 32'h0,    1, 32'h7000, 1, 2'b00, 32'h0,   2'b00, 32'h0,   0, A_ERR,        0, 0, 1, 32'h2000, 0};
      tbl[11] = '{0, 32'h0,    0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   0, A_ERR,        0, 1, 1, 32'h7000, 1};
      tbl[12] = '{1, 32'h0400, 1, 32'h1FF0, 0, 2'b10, 32'h000, 2'b01, 32'hFF0, 0, A_ERR,        0, 0, 1, 32'h7000, 1};
      tbl[13] = '{0, 32'h0,    0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   1, 32'hA0100000, 0, 0, 1, 32'h7000, 1};
      tbl[14] = '{0, 32'h0,    0, 32'h0,    1, 2'b00, 32'h0,   2'b00, 32'h0,   0, 32'hA0100000, 0, 0, 1, 32'h7000, 1};
      tbl[15] = '{0, 32'h0,    0, 32'h0,    0, 2'b00, 32'h0,   2'b00, 32'h0,   0, 32'hA0100000, 0, 0, 0, 32'h7000, 1};

      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.r_en = 1'b0; bus_a.r_addr = '0; bus_a.w_en = 1'b0; bus_a.w_addr = '0; bus_a.w_data = '0;
      bus_b.r_en = 1'b0; bus_b.r_addr = '0; bus_b.w_en = 1'b0; bus_b.w_addr = '0; bus_b.w_data = '0;
      a_err_clr = 1'b0;
      b_err_clr = 1'b0;

      // Reset state while reset is held.
      #12;
      chk("rst A r_valid", 32'(bus_a.r_valid), 32'h0);
      chk("rst A r_data", bus_a.r_data, 32'h0);
      chk("rst A w_err", 32'(bus_a.w_err), 32'h0);
      chk("rst B r_valid", 32'(bus_b.r_valid), 32'h0);
      chk("rst B err_flag", 32'(b_err_flag), 32'h0);
      chk("rst B err_addr", b_err_addr, 32'h0);
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Directed table on instance A.
      for (int k = 0; k < 16; k++) begin
         bus_a.r_en   = tbl[k].r_en;
         bus_a.r_addr = tbl[k].r_addr;
         bus_a.w_en   = tbl[k].w_en;
         bus_a.w_addr = tbl[k].w_addr;
         bus_a.w_data = 32'h1234_0000 | 32'(k);
         a_err_clr    = tbl[k].clr;
         #4;
         chk($sformatf("A%0d s_r_en", k), 32'(a_s_r_en), 32'(tbl[k].e_sren));
         if (tbl[k].e_sren != 0) chk($sformatf("A%0d s_r_addr", k), a_s_r_addr, tbl[k].e_sraddr);
         chk($sformatf("A%0d s_w_en", k), 32'(a_s_w_en), 32'(tbl[k].e_swen));
         if (tbl[k].e_swen != 0) chk($sformatf("A%0d s_w_addr", k), a_s_w_addr, tbl[k].e_swaddr);
         chk($sformatf("A%0d r_valid", k), 32'(bus_a.r_valid), 32'(tbl[k].e_rvalid));
         chk($sformatf("A%0d r_data", k), bus_a.r_data, tbl[k].e_rdata);
         chk($sformatf("A%0d r_err", k), 32'(bus_a.r_err), 32'(tbl[k].e_rerr));
         chk($sformatf("A%0d w_err", k), 32'(bus_a.w_err), 32'(tbl[k].e_werr));
         chk($sformatf("A%0d err_flag", k), 32'(a_err_flag), 32'(tbl[k].e_flag));
         chk($sformatf("A%0d err_addr", k), a_err_addr, tbl[k].e_eaddr);
         chk($sformatf("A%0d err_is_write", k), 32'(a_err_is_write), 32'(tbl[k].e_iw));
         @(posedge clk);
         #1;
      end
      bus_a.r_en = 1'b0;
      bus_a.w_en = 1'b0;
      a_err_clr  = 1'b0;

      // Instance B: back-to-back alternating reads with a changing address.
      b_cycle(1, 32'h1000, 0, 0, 0, 0);
      b_cycle(1, 32'h0400, 0, 0, 0, 0);
      b_cycle(1, 32'h1008, 0, 0, 0, 0);
      b_cycle(1, 32'h0404, 0, 0, 0, 0);
      repeat (3) b_cycle(0, 0, 0, 0, 0, 0);

      // Overlapping slots: the lowest index must take the write alone.
      b_cycle(0, 0, 1, 32'h1010, 32'hCAFE_0001, 0);
      b_cycle(0, 0, 0, 0, 0, 0);

      // Random traffic.
      for (int n = 0; n < 400; n++)
         b_cycle($urandom_range(0, 2) != 0, pick_addr(), 1'($urandom_range(0, 1)),
                 pick_addr(), $urandom, $urandom_range(0, 15) == 0);
      repeat (3) b_cycle(0, 0, 0, 0, 0, 0);

      // Reset with two reads in flight and an error captured.
      b_cycle(1, 32'h3000, 0, 0, 0, 0);
      b_cycle(1, 32'h1000, 0, 0, 0, 0);
      b_cycle(1, 32'h0404, 0, 0, 0, 0);
      bus_b.r_en = 1'b0;
      bus_b.w_en = 1'b0;
      rst_b      = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #4;
         chk($sformatf("R%0d r_valid", n), 32'(bus_b.r_valid), 32'h0);
         if (n < 2) begin
            chk($sformatf("R%0d err_flag", n), 32'(b_err_flag), 32'h0);
            chk($sformatf("R%0d err_addr", n), b_err_addr, 32'h0);
            chk($sformatf("R%0d err_is_write", n), 32'(b_err_is_write), 32'h0);
            chk($sformatf("R%0d r_data", n), bus_b.r_data, 32'h0);
         end
         @(posedge clk);
         #1;
         if (n == 1) rst_b = 1'b0;
      end
      q.delete();
      m_flag  = 1'b0;
      m_eaddr = '0;
      m_iw    = 1'b0;
      m_werr  = 1'b0;
      m_last  = '0;
      b_cyc  += 4;

      for (int n = 0; n < 100; n++)
         b_cycle($urandom_range(0, 1) != 0, pick_addr(), 1'($urandom_range(0, 1)),
                 pick_addr(), $urandom, $urandom_range(0, 7) == 0);
      repeat (3) b_cycle(0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/data_bus_xbar.md
Name: data_bus_xbar

Overview:
Parametrised successor to the fixed two-target data bus. Routes one read port and one write port from the core to N_SLAVES memory/peripheral targets through a per-slave base/mask address map. Tracks read-return selection in a latency pipeline, so r_addr need not stay stable, and flags unmapped accesses with a sticky error capture register. Sits between the core's data port and data memory, GPIO and future peripherals.

Parameters:
N_SLAVES, 4, number of targets (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {N_SLAVES{32'h0}}, packed N_SLAVES*ADDR_W base addresses, slot i at bits [i*ADDR_W +: ADDR_W]
SLV_MASK, {N_SLAVES{32'hFFFFF000}}, packed match masks; hit_i = (addr & MASK_i) == BASE_i
RD_LAT, 1, slave read latency in cycles from s_r_en to valid s_r_data (1..4)
ERR_DATA, 32'h0, r_data value returned for unmapped reads

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
r_en  in  1  read request, one per cycle, fully pipelined
r_addr  in  ADDR_W  read address, sampled only in the r_en cycle
r_data  out  DATA_W  read data, valid when r_valid
r_valid  out  1  read return strobe, RD_LAT cycles after r_en
r_err  out  1  return is from an unmapped address (qualified by r_valid)
w_en  in  1  write request
w_addr  in  ADDR_W  write address
w_data  in  DATA_W  write data
w_err  out  1  registered pulse, one cycle after an unmapped write
s_r_en  out  N_SLAVES  per-slave read enable
s_r_addr  out  ADDR_W  slave-local read address, r_addr & ~MASK_sel, shared by all slaves
s_r_data  in  N_SLAVES*DATA_W  packed slave read data
s_w_en  out  N_SLAVES  per-slave write enable
s_w_addr  out  ADDR_W  slave-local write address, w_addr & ~MASK_sel
s_w_data  out  DATA_W  w_data passthrough
err_flag  out  1  sticky: an unmapped access has occurred
err_addr  out  ADDR_W  address of the first captured error
err_is_write  out  1  captured error was a write
err_clr  in  1  clears err_flag

Behaviour:
- Reset values: r_valid=0, r_err=0, r_data=0, w_err=0, err_flag=0, err_addr=0, err_is_write=0, read pipeline empty.
- Decode is combinational. Lowest matching index wins on overlapping maps. No match is a miss. Read and write decode independently; both may hit in the same cycle, same slave included.
- s_r_en[i] = r_en & sel_r==i & hit. s_w_en likewise. On a miss all enables stay 0 and the slave address outputs are don't-care (driven with the unmasked address).
- Read pipeline: RD_LAT-stage shift register of {valid, miss, idx[clog2(N_SLAVES)]}, loaded every cycle. Back-to-back reads give back-to-back returns with no bubbles.
- Output stage, when valid: r_valid=1; r_data=s_r_data[idx] on hit or ERR_DATA on miss; r_err=miss. r_data is combinationally muxed from the registered idx, and holds its last value while not valid.
- Unmapped write: no slave enable; w_err=1 exactly one cycle later.
- Error capture:
  - Priority when err_flag=0 and there is a miss: read miss wins over a simultaneous write miss. Capture the address and err_is_write, set err_flag.
  - When err_flag=1, further misses do not overwrite the capture.
  - err_clr with no miss that cycle: err_flag goes to 0; err_addr is retained.
  - err_clr in the same cycle as a miss: the new miss is captured and err_flag stays 1 (set wins).
- Reset mid-read: all in-flight returns are dropped and r_valid is never asserted for them.
- No backpressure: slaves must accept every enable and return data in exactly RD_LAT cycles.

Decomposition:
- Shared package/header: default map constants (DATA_MEM_BASE 32'h1000 / MASK 32'hFFFFF000, GPIO_A_BASE 32'h400 / MASK 32'hFFFFFC00) and an IDX_W = clog2(N_SLAVES) function.
- One sub-module: bus_addr_decoder (address -> hit, idx, local address). Instantiated twice, for read and for write.

Test Plan:
- Map {0x1000/0xFFFFF000, 0x400/0xFFFFFC00}, RD_LAT=1. Read 0x1004 -> s_r_en=2'b01, s_r_addr=0x004, next cycle r_valid=1, r_data=slave0 data, r_err=0.
- r_en on 4 consecutive cycles alternating 0x1000/0x400, r_addr changed every cycle, RD_LAT=2 -> 4 consecutive r_valid with data from slave 0,1,0,1 in order.
- Read 0x3000 -> no s_r_en, r_valid with r_data=ERR_DATA, r_err=1, err_flag=1, err_addr=0x3000, err_is_write=0. Then write miss 0x5000 -> w_err pulse, err_addr stays 0x3000.
- Same cycle: read miss 0x2000 and write miss 0x6000 with err_flag=0 -> err_addr=0x2000, err_is_write=0. Later err_clr with a simultaneous write miss 0x7000 -> err_flag stays 1, err_addr=0x7000, err_is_write=1.
- Overlapping map: slot0 0x1000/0xFFFFF000, slot1 0x1000/0xFFFFFF00. Write 0x1010 -> s_w_en=2'b01 only.
- Assert rst while two reads are in flight (RD_LAT=2) -> r_valid stays 0 through reset and the two following cycles, and the error registers are at 0.
